axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Parametrised AXI3 read-channel arbiter: NUM_M request masters (fetch, load, future cache refill, etc.) share one AXI AR/R port toward the interconnect.
- Generalises the fixed inst/load two-way mux in the CPU top. It adds a selectable fixed-priority or round-robin policy, bursts up to 16 beats, per-master ID tagging, and an unexpected-RID error flag.
- One transaction is in flight at a time.

Parameters:
- NUM_M, 2, number of request masters (2..8); master 0 is fetch.
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, AXI ID width; must satisfy 2^ID_W >= NUM_M.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_araddr  in  NUM_M*ADDR_W  per-master address, master i at slice [i*ADDR_W +: ADDR_W]
- s_arlen  in  NUM_M*4  per-master burst length minus 1
- s_arvalid  in  NUM_M  per-master request
- s_arready  out  NUM_M  one-hot, pulses on the AR handshake of the granted master
- s_rdata  out  DATA_W  read data, broadcast to all masters
- s_rresp  out  2  read response, broadcast
- s_rlast  out  1  last beat, broadcast
- s_rvalid  out  NUM_M  one-hot, valid only to the owning master
- s_rready  in  NUM_M  per-master ready
- m_arid  out  ID_W  equals the granted master index
- m_araddr  out  ADDR_W
- m_arlen  out  4
- m_arvalid  out  1
- m_arready  in  1
- m_rid  in  ID_W
- m_rdata  in  DATA_W
- m_rresp  in  2
- m_rlast  in  1
- m_rvalid  in  1
- m_rready  out  1
- err_rid  out  1  sticky; set when an R beat arrives with m_rid != grant
- busy  out  1  high when state != IDLE

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid is set, select grant per the policy.
  - Register m_araddr/m_arlen/m_arid from the granted master's slice.
  - Set m_arvalid = 1 and move to ADDR next cycle. Latency from request to m_arvalid is 1 cycle.
- ADDR:
  - Hold m_arvalid and the address fields stable until m_arready.
  - On the handshake: m_arvalid <= 0; s_arready[grant] = 1 combinationally in that cycle; go to DATA.
  - Masters must hold s_arvalid and their fields until s_arready.
- DATA:
  - s_rvalid[grant] = m_rvalid; other bits are 0. m_rready = s_rready[grant].
  - s_rdata, s_rresp and s_rlast pass through combinationally; no buffering and zero added latency.
  - On m_rvalid & m_rready & m_rlast, return to IDLE. A new grant is possible on the next cycle, so there are 2 dead cycles between back-to-back bursts.
- Round-robin:
  - Priority pointer = (last grant + 1) mod NUM_M; the pointer updates on entry to ADDR.
  - The search wraps from NUM_M-1 to 0.
- Fixed priority: the lowest asserted index wins. Master 0 can starve the others; this is intended.
- Request changes: a s_arvalid deasserted after the grant has no effect; the request latched at grant is issued.
- err_rid:
  - Set on any m_rvalid beat whose m_rid != latched grant; the beat is still delivered to the grant owner.
  - Cleared only by reset.
- Spurious data: m_rvalid while in IDLE or ADDR → m_rready = 0; the beat is not consumed and err_rid is set.
- Reset values: state = IDLE, m_arvalid = 0, m_araddr = 0, m_arlen = 0, m_arid = 0, m_rready = 0, s_arready = 0, s_rvalid = 0, err_rid = 0, busy = 0, RR pointer = 0.
- Reset mid-transaction:
  - Abandons the burst immediately with all outputs at reset values.
  - The downstream interconnect must be reset in the same cycle. No drain is performed.

Decomposition:
- Shared package cpu_axi_pkg: AXI constants (ARSIZE_WORD = 3'b010, BURST_INCR = 2'b01, RESP_OKAY/SLVERR), arbiter state encoding, RR_MODE enum.
- One sub-module, rr_pick:
  - Combinational NUM_M-wide priority picker taking a request vector and a start pointer, returning a one-hot grant and an index.
  - Used with pointer 0 for fixed priority.
- ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT constants stay at the top level, not in this block.

Test Plan:
- Single read: NUM_M=2; master 1 requests 0x1FC0_0100 with len 3; slave returns 4 beats with rid 1. Expect:
  - m_arvalid one cycle after the request; m_arid = 1; s_arready[1] pulses once.
  - All 4 beats are seen only on s_rvalid[1]; busy falls the cycle after the rlast handshake.
- Simultaneous requests, RR_MODE=0: masters 0 and 1 assert in the same cycle, each len 0. Expect master 0 served first and master 1 second; m_arid sequence 0, 1.
- Round-robin wrap: NUM_M=3, RR_MODE=1, all three requesting continuously for 6 transactions. Expect grant order 0, 1, 2, 0, 1, 2.
- Backpressure: hold m_arready low for 5 cycles, then drop s_rready[grant] on beat 2 of a len-7 burst. Expect:
  - m_araddr and m_arlen stable throughout ADDR.
  - m_rready low while s_rready is low; no beat lost or duplicated (8 beats total).
- RID error: return beat 0 of a master-0 burst with rid 1. Expect err_rid = 1 from the next cycle and held; data still goes to master 0.
- Mid-burst reset: assert areset after beat 1 of a len-3 burst. Expect:
  - The next cycle has state IDLE and all outputs zero.
  - A fresh request after reset is granted normally with m_arid = its index.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-side definitions for the CPU bus blocks.
//   - AXI encodings used by the CPU top (size, burst, response codes)
//   - State encoding of the read arbiter
//   - Arbitration policy selector values
package cpu_axi_pkg;

    localparam logic [2:0] ARSIZE_WORD = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Arbiter FSM encoding
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ADDR = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    typedef enum logic {
        RR_FIXED = 1'b0,
        RR_ROUND = 1'b1
    } rr_mode_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority picker.
//   req   : request vector, one bit per master
//   start : index that has highest priority; search wraps N-1 -> 0
//   gnt   : one-hot grant (all zero when no request)
//   idx   : binary index of the granted master
//   any   : at least one request present
// Driving start with 0 gives plain fixed priority (lowest index wins).
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;

    always_comb begin
        // Rotating the doubled vector puts master 'start' at bit 0, so the
        // first set bit of rot is the winner in wrap-around order.
        dbl = {req, req} >> start;
        rot = dbl[N-1:0];
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                sum = {1'b0, start} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                idx = sum[IDX_W-1:0];
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI3 read-channel arbiter: NUM_M masters share one AR/R port, one
// transaction in flight at a time.
//   aclk, areset          : clock, synchronous active-high reset
//   s_ar*                 : per-master request (address, len, valid/ready)
//   s_r*                  : read data broadcast; s_rvalid one-hot to owner
//   m_ar*, m_r*           : single downstream AXI read port
//   err_rid               : sticky, R beat with wrong ID or with no owner
//   busy                  : FSM not idle
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. A valid, once raised, stays high with its payload stable until that
// transfer; ready may rise or fall freely and never waits on a later valid.
module axi_rd_arbiter #(
    parameter int NUM_M   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int RR_MODE = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_M*ADDR_W-1:0] s_araddr,
    input  logic [NUM_M*4-1:0]      s_arlen,
    input  logic [NUM_M-1:0]        s_arvalid,
    output logic [NUM_M-1:0]        s_arready,
    output logic [DATA_W-1:0]       s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic [NUM_M-1:0]        s_rvalid,
    input  logic [NUM_M-1:0]        s_rready,
    output logic [ID_W-1:0]         m_arid,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [3:0]              m_arlen,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_W-1:0]         m_rid,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    err_rid,
    output logic                    busy
);

    import cpu_axi_pkg::*;

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [1:0]        state_q, state_d;
    logic [NUM_M-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        arlen_q, arlen_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic              arvalid_q, arvalid_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  pick_start;
    logic [NUM_M-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_len;
    logic [IDX_W:0]    ptr_inc;

    assign pick_start = (RR_MODE == int'(RR_ROUND)) ? ptr_q : '0;

    rr_pick #(
        .N     (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (s_arvalid),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // AND-OR mux of the winning master's request fields
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
                sel_len  = s_arlen[i*4 +: 4];
            end
        end
    end

    // Next round-robin pointer: one past the master being granted
    always_comb begin
        ptr_inc = {1'b0, pick_idx} + 1'b1;
        if (ptr_inc == (IDX_W+1)'(NUM_M)) begin
            ptr_inc = '0;
        end
    end

    // Channel steering. Everything is forced quiet while reset is asserted
    // so the abandoned burst cannot complete a handshake in that cycle.
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        if (!areset) begin
            if (state_q == ARB_ADDR && m_arready) begin
                s_arready = gnt_q;
            end
            if (state_q == ARB_DATA) begin
                s_rvalid = gnt_q & {NUM_M{m_rvalid}};
                m_rready = |(s_rready & gnt_q);
                s_rdata  = m_rdata;
                s_rresp  = m_rresp;
                s_rlast  = m_rlast;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d   = ARB_ADDR;
                    gnt_d     = pick_gnt;
                    ptr_d     = ptr_inc[IDX_W-1:0];
                    araddr_d  = sel_addr;
                    arlen_d   = sel_len;
                    arid_d    = ID_W'(pick_idx);
                    arvalid_d = 1'b1;
                end
            end
            ARB_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Any R beat is suspect unless it arrives in DATA carrying our ID;
    // beats seen outside DATA have no owner and are left unconsumed.
    always_comb begin
        err_d = err_q;
        if (m_rvalid && (state_q != ARB_DATA || m_rid != arid_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
        end
    end

    assign m_arid    = arid_q;
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arvalid = arvalid_q;
    assign err_rid   = err_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule
